multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Parametrised, multi-cycle signed multiply/divide unit for the 5-stage pipeline's execute stage; serves the ALU mul/div opcodes (00110, 00111).
- Operands are latched on a start pulse and iterated one bit per cycle. The unit reports result-ready, exception and busy so the pipeline can stall the DX latch.
- Adds a pipeline-flush abort path for jump/branch squash.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived localparam, not user-overridable.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- data_operandA  in  WIDTH  multiplicand or dividend, signed two's complement.
- data_operandB  in  WIDTH  multiplier or divisor, signed two's complement.
- ctrl_MULT  in  1  start-multiply pulse; sampled only in IDLE.
- ctrl_DIV  in  1  start-divide pulse; sampled only in IDLE.
- flush  in  1  synchronous abort of an in-flight operation.
- data_result  out  WIDTH  signed result; held until the next accepted start.
- data_exception  out  1  overflow or divide-by-zero; valid with data_resultRDY and held with data_result.
- data_resultRDY  out  1  one-cycle pulse when the result is valid.
- busy  out  1  high while in RUN; the pipeline stall source.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ctrl_MULT=1 at an edge: latch operands and op=MUL, clear the accumulator, go to RUN with counter=0.
  - ctrl_DIV=1 at an edge: latch operands and op=DIV, go to RUN with counter=0.
  - Both high at the same edge: MUL wins; ctrl_DIV is ignored.
  - ctrl_DIV with data_operandB=0: skip RUN and go to DONE with result=0, exception=1.
- RUN:
  - busy=1.
  - One shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle on operand magnitudes. Counter increments each cycle.
  - After WIDTH steps, apply the sign correction and go to DONE.
  - ctrl_MULT/ctrl_DIV are ignored while in RUN.
- DONE:
  - data_resultRDY=1 for exactly one cycle, with data_result and data_exception valid.
  - Unconditionally return to IDLE next edge.
  - A start pulse asserted during DONE is ignored; the earliest accept is the first IDLE cycle.
- Latency: start accepted at edge 0 → data_resultRDY high in the cycle after edge WIDTH+1, i.e. WIDTH+1 cycles.
  - Divide-by-zero latency is 1 cycle.
  - busy is low in DONE.
- MUL arithmetic:
  - Full 2·WIDTH signed product is formed; data_result = low WIDTH bits.
  - data_exception=1 iff the upper WIDTH+1 bits of the product are not all equal, i.e. the product does not fit in signed WIDTH.
- DIV arithmetic:
  - Signed quotient truncated toward zero; the remainder is discarded.
  - MIN/−1: data_result=MIN, data_exception=1.
  - |A|<|B|: result 0, exception 0.
- flush=1 at an edge, in RUN or DONE: go to IDLE and suppress or clear data_resultRDY.
  - data_result and data_exception keep their previous values.
  - flush in IDLE has no effect.
  - flush and a start at the same IDLE edge: flush wins and the start is dropped.
- reset asserted mid-operation: the operation is abandoned immediately and all outputs return to reset values.
- Sampled inputs are never X-propagated into the state; an operand change after the start edge has no effect.

Decomposition:
- Shared package (processor-wide): ALU opcode constants MUL=5'b00110 and DIV=5'b00111, the FSM state encoding, and a WIDTH default constant shared with the ALU and pipeline latches.
- One sub-module, iter_counter: CNT_W-bit counter with synchronous clear and enable, plus terminal-count flag at WIDTH−1.
- Datapath and FSM stay in multdiv_iter.

Test Plan (all at WIDTH=32):
- MUL 7 × −6 → data_resultRDY exactly once, 33 cycles after the start edge; data_result=0xFFFFFFD6 (−42); exception=0; busy high for 32 cycles.
- MUL 0x00010000 × 0x00010000 → data_result=0x00000000, exception=1. Then MUL 0x7FFFFFFF × 1 → data_result=0x7FFFFFFF, exception=0.
- DIV −45 / 7 → data_result=0xFFFFFFFA (−6). DIV 0x80000000 / −1 → data_result=0x80000000, exception=1. DIV 5 / 0 → data_resultRDY 1 cycle after start, result=0, exception=1.
- Start MUL 3×4; pulse ctrl_DIV at cycles 5 and 33 → the DIV pulses are ignored, result=12. A new start at cycle 34 (IDLE) is accepted.
- MUL 9×9 with flush at cycle 10 → no data_resultRDY; busy drops the next cycle; data_result keeps its prior value. A following DIV 100/10 yields 10.
- reset driven 0 for 1 ns mid-RUN, asynchronously between edges → busy, data_resultRDY, data_result and data_exception go to 0 immediately, and no ready pulse follows.

Source files
------------

// File: rtl/multdiv_iter_pkg.sv
// Shared processor-wide definitions for the iterative multiply/divide unit.
// Holds the ALU opcodes, the FSM encoding and the default datapath width.
package multdiv_iter_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [4:0] ALU_OP_MUL = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: synchronous clear, count enable, and a terminal-count
// flag raised while the count sits at WIDTH-1 (the last iteration step).
module iter_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign-corrected on the way out.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV; outputs hold the last result
// RUN   | iterating, busy=1, WIDTH steps
// DONE  | result formed; registered with the ready pulse on the way to IDLE
module multdiv_iter
    import multdiv_iter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_next;
    op_t                r_op;
    logic               r_neg;
    logic               r_dz;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;

    logic               w_accept;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_tc;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_sub;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic               w_mul_exc;
    logic               w_div_exc;
    logic [WIDTH-1:0]   w_fin_result;
    logic               w_fin_exc;

    iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock (clock),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush && (ctrl_MULT || ctrl_DIV)) begin
                    w_accept  = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (!ctrl_MULT && (data_operandB == '0)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_tc) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // MUL: {r_hi,r_lo} is the product/multiplier pair, r_opnd the multiplicand.
    // DIV: r_hi is the partial remainder, r_lo dividend bits in / quotient bits out.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;

    assign w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_mul_exc = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot    = r_neg ? -r_lo : r_lo;
    // A positive quotient with the top bit set only arises from MIN / -1.
    assign w_div_exc = ~r_neg & r_lo[WIDTH-1];

    always_comb begin
        w_fin_result = '0;
        w_fin_exc    = 1'b0;
        if (r_dz) begin
            w_fin_exc = 1'b1;
        end else if (r_op == OP_MUL) begin
            w_fin_result = w_prod[WIDTH-1:0];
            w_fin_exc    = w_mul_exc;
        end else begin
            w_fin_result = w_quot;
            w_fin_exc    = w_div_exc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op   <= OP_MUL;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (w_accept) begin
            r_op   <= ctrl_MULT ? OP_MUL : OP_DIV;
            r_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz   <= ~ctrl_MULT & (data_operandB == '0);
            r_opnd <= ctrl_MULT ? w_mag_a : w_mag_b;
            r_hi   <= '0;
            r_lo   <= ctrl_MULT ? w_mag_b : w_mag_a;
        end else if ((r_state == ST_RUN) && !flush) begin
            if (r_op == OP_MUL) begin
                r_hi <= w_mul_sum[WIDTH:1];
                r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end else begin
                r_hi <= w_div_ok ? w_div_sub : w_div_shift[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= (r_state == ST_DONE) && !flush;
            if ((r_state == ST_DONE) && !flush) begin
                r_result <= w_fin_result;
                r_exc    <= w_fin_exc;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state == ST_RUN);

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter at WIDTH=32: directed cases plus
// random operands compared against a plain-arithmetic reference model.
module tb_multdiv_iter;

    localparam int W    = 32;
    localparam int HALF = 50;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic         flush;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    multdiv_iter #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .flush          (flush),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #HALF clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers.
    task automatic ref_op(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic e);
        longint sa, sb, p, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            p = sa * sb;
            r = p[W-1:0];
            e = (p != longint'($signed(p[W-1:0])));
        end else if (sb == 0) begin
            r = '0;
            e = 1'b1;
        end else if (sa == -64'sd2147483648 && sb == -1) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = sa / sb;
            r = q[W-1:0];
            e = 1'b0;
        end
    endtask

    // Called at a negedge; the start is taken at the following posedge.
    task automatic run_op(input bit is_mul, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int busy_n, output logic [W-1:0] res,
                          output logic exc, output logic rdy_after);
        data_operandA = av;
        data_operandB = bv;
        ctrl_MULT     = is_mul;
        ctrl_DIV      = !is_mul;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat    = 0;
        busy_n = 0;
        while (!data_resultRDY && lat < 200) begin
            if (busy) busy_n++;
            @(negedge clock);
            lat++;
        end
        res = data_result;
        exc = data_exception;
        @(negedge clock);
        rdy_after = data_resultRDY;
    endtask

    task automatic op_check(input string tag, input bit is_mul, input logic [W-1:0] av,
                            input logic [W-1:0] bv);
        logic [W-1:0] exp_r, res;
        logic         exp_e, exc, rdy_after;
        int           lat, busy_n;
        bit           dz;
        dz = !is_mul && (bv == '0);
        ref_op(is_mul, av, bv, exp_r, exp_e);
        run_op(is_mul, av, bv, lat, busy_n, res, exc, rdy_after);
        check({tag, "_latency"}, 64'(lat), dz ? 64'd1 : 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_n), dz ? 64'd0 : 64'd32);
        check({tag, "_result"}, 64'(res), 64'(exp_r));
        check({tag, "_exception"}, 64'(exc), 64'(exp_e));
        check({tag, "_single_pulse"}, 64'(rdy_after), 64'd0);
    endtask

    initial begin
        int           rdy_cnt;
        int           rdy_k;
        logic [W-1:0] res_k;
        logic         exc_k;
        logic [W-1:0] ra, rb;
        bit           rm;

        reset = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        flush     = 1'b0;
        #10;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        op_check("mul_7_x_m6", 1'b1, 32'd7, -32'sd6);
        op_check("mul_ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
        op_check("mul_max_x1", 1'b1, 32'h7FFF_FFFF, 32'd1);
        op_check("mul_min_x_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        op_check("div_m45_7", 1'b0, -32'sd45, 32'd7);
        op_check("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        op_check("div_5_0", 1'b0, 32'd5, 32'd0);
        op_check("div_3_m7", 1'b0, 32'd3, -32'sd7);
        op_check("div_min_1", 1'b0, 32'h8000_0000, 32'd1);

        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                ra = 32'($urandom_range(0, 40)) - 32'd20;
                rb = 32'($urandom_range(0, 40)) - 32'd20;
            end else begin
                ra = $urandom;
                rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300)) - 32'd150;
            end
            op_check($sformatf("rand%0d_%s", i, rm ? "mul" : "div"), rm, ra, rb);
        end

        // Start pulses in RUN (edge 5) and DONE (edge 33) must be ignored.
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        rdy_cnt = 0;
        rdy_k   = -1;
        res_k   = '0;
        exc_k   = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            data_operandA = 32'd8;
            data_operandB = 32'd2;
            ctrl_DIV = (k == 5 || k == 33);
            @(negedge clock);
            ctrl_DIV = 1'b0;
            if (k == 5) check("ignore_div_busy_run", 64'(busy), 64'd1);
            if (data_resultRDY) begin
                rdy_cnt++;
                rdy_k = k;
                res_k = data_result;
                exc_k = data_exception;
            end
        end
        check("ignore_div_rdy_count", 64'(rdy_cnt), 64'd1);
        check("ignore_div_rdy_edge", 64'(rdy_k), 64'd33);
        check("ignore_div_result", 64'(res_k), 64'd12);
        check("ignore_div_exc", 64'(exc_k), 64'd0);
        op_check("accept_at_34_div_100_10", 1'b0, 32'd100, 32'd10);

        // Flush mid-RUN: no ready pulse, prior result (10) held.
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clock);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'd0);
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check("flush_no_rdy", 64'(rdy_cnt), 64'd0);
        check("flush_result_held", 64'(data_result), 64'd10);
        check("flush_exc_held", 64'(data_exception), 64'd0);

        // Flush and start on the same IDLE edge: start dropped.
        data_operandA = 32'd2;
        data_operandB = 32'd3;
        ctrl_MULT = 1'b1;
        flush     = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        flush     = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check("flush_start_no_rdy", 64'(rdy_cnt), 64'd0);
        op_check("after_flush_div_100_10", 1'b0, 32'd100, 32'd10);
        op_check("mul_max_x3", 1'b1, 32'h7FFF_FFFF, 32'd3);

        // Asynchronous reset pulse between edges while in RUN.
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clock);
        #10;
        reset = 1'b0;
        #5;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_rdy", 64'(data_resultRDY), 64'd0);
        check("async_rst_result", 64'(data_result), 64'd0);
        check("async_rst_exc", 64'(data_exception), 64'd0);
        #5;
        reset = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        check("async_rst_no_rdy", 64'(rdy_cnt), 64'd0);
        check("async_rst_idle_busy", 64'(busy), 64'd0);
        op_check("post_rst_mul_9_9", 1'b1, 32'd9, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
